// File: rtl/divider_axil_slave.sv
// divider_axil_slave: AXI4-Lite register block around a 32-bit unsigned restoring radix-2 divider.
// Latency: AW/W ready one cycle after both valid, B the cycle after; AR ready one cycle after valid, R the cycle after; START handshake -> DONE in 34 cycles.
// Backpressure: no write is accepted while BVALID waits on BREADY; no read is accepted while RVALID waits on RREADY.
// Ports: ACLK/ARESET (async, active-high); S_AXI_AW*/W*/B* write channels; S_AXI_AR*/R* read channels; IRQ = DONE & IE.
// Map (word slots): 0 DIVIDEND, 1 DIVISOR, 2 CTRL/STATUS {DZ,BUSY,IE,DONE,START}, 3 QUOTIENT, 4 REMAINDER, 5-7 read zero.
module divider_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              IRQ
);

    typedef enum logic [1:0] {IDLE, RUN, FIN, ZERO} state_t;

    localparam logic [2:0] A_DIVIDEND = 3'd0;
    localparam logic [2:0] A_DIVISOR  = 3'd1;
    localparam logic [2:0] A_CTRL     = 3'd2;
    localparam logic [2:0] A_QUOT     = 3'd3;
    localparam logic [2:0] A_REM      = 3'd4;

    state_t      state_q, state_d;

    logic        aw_ready_q, bvalid_q, ar_ready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] dividend_q, divisor_q, quotient_q, remainder_q;
    logic        ie_q, done_q, dz_q, busy_q, start_pend_q;
    // work_q starts as the dividend and shifts quotient bits in from the right.
    logic [31:0] work_q, dsr_q, rem_q;
    logic [4:0]  cnt_q;

    logic        wr_fire, rd_fire, start_wr, done_clr;
    logic [2:0]  wr_idx;
    logic [32:0] shifted, trial;
    logic [31:0] rd_word, ctrl_word;
    logic        unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign IRQ           = done_q & ie_q;

    // aw_ready_q is only raised while BVALID is low, so a fire implies no response is pending.
    assign wr_fire  = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire  = ar_ready_q & S_AXI_ARVALID;
    assign wr_idx   = S_AXI_AWADDR[4:2];
    assign start_wr = wr_fire & (wr_idx == A_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
    assign done_clr = wr_fire & (wr_idx == A_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[1];

    // Partial remainder is always below the divisor, so the 33-bit trial cannot overflow.
    assign shifted = {rem_q, work_q[31]};
    assign trial   = shifted - {1'b0, dsr_q};

    assign ctrl_word = {27'd0, dz_q, busy_q, ie_q, done_q, 1'b0};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = strb[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        rd_word = '0;
        case (S_AXI_ARADDR[4:2])
            A_DIVIDEND: rd_word = dividend_q;
            A_DIVISOR:  rd_word = divisor_q;
            A_CTRL:     rd_word = ctrl_word;
            A_QUOT:     rd_word = quotient_q;
            A_REM:      rd_word = remainder_q;
            default:    rd_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_pend_q) state_d = (divisor_q == '0) ? ZERO : RUN;
            RUN:       if (cnt_q == '0) state_d = FIN;
            FIN, ZERO: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Bus handshakes: ready is a one-cycle pulse, valid holds until the master takes it.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            aw_ready_q <= ~aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
            if (wr_fire)                  bvalid_q <= 1'b1;
            else if (S_AXI_BREADY)        bvalid_q <= 1'b0;
            ar_ready_q <= ~ar_ready_q & S_AXI_ARVALID & ~rvalid_q;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Register bank and divider datapath. The FSM case comes last so a FIN/ZERO
    // DONE set overrides a same-cycle DONE clear.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            dividend_q   <= '0;
            divisor_q    <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            ie_q         <= 1'b0;
            done_q       <= 1'b0;
            dz_q         <= 1'b0;
            busy_q       <= 1'b0;
            start_pend_q <= 1'b0;
            work_q       <= '0;
            dsr_q        <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
        end else begin
            start_pend_q <= start_wr & ~busy_q;
            if (wr_fire) begin
                case (wr_idx)
                    A_DIVIDEND: dividend_q <= merge(dividend_q, S_AXI_WDATA, S_AXI_WSTRB);
                    A_DIVISOR:  divisor_q  <= merge(divisor_q, S_AXI_WDATA, S_AXI_WSTRB);
                    A_CTRL:     if (S_AXI_WSTRB[0]) ie_q <= S_AXI_WDATA[2];
                    default:    ;
                endcase
            end
            if (done_clr) done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_pend_q) begin
                    work_q <= dividend_q;
                    dsr_q  <= divisor_q;
                    rem_q  <= '0;
                    cnt_q  <= 5'd31;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    dz_q   <= 1'b0;
                end
                RUN: begin
                    work_q <= {work_q[30:0], ~trial[32]};
                    rem_q  <= trial[32] ? shifted[31:0] : trial[31:0];
                    cnt_q  <= cnt_q - 5'd1;
                end
                FIN: begin
                    quotient_q  <= work_q;
                    remainder_q <= rem_q;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                end
                ZERO: begin
                    quotient_q  <= '1;
                    remainder_q <= work_q;
                    dz_q        <= 1'b1;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_axil_slave.sv
// tb_divider_axil_slave: directed and randomized bench for divider_axil_slave.
// Latency: drives and samples on the falling clock edge; divide latency measured from the START handshake edge.
// Backpressure: exercises held BREADY/RREADY and a queued second write.
module tb_divider_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [4:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [4:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        IRQ;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cyc = 0;

    divider_axil_slave dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .IRQ           (IRQ)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One write; hs_cyc is the clock count of the AW/W handshake edge.
    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit wait_b);
        int ok;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin ok = 1; break; end
        end
        chk("aw_hs", ok, 1);
        @(negedge ACLK);
        hs_cyc = cyc;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("bvalid_up", 32'(S_AXI_BVALID), 1);
        chk("bresp", 32'(S_AXI_BRESP), 0);
        if (wait_b) begin
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                if (!S_AXI_BVALID) begin ok = 1; break; end
                @(negedge ACLK);
            end
            chk("b_done", ok, 1);
        end
    endtask

    task automatic axi_rd(input logic [4:0] a, output logic [31:0] d);
        int ok;
        @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin ok = 1; break; end
        end
        chk("ar_hs", ok, 1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        chk("rvalid_up", 32'(S_AXI_RVALID), 1);
        chk("rresp", 32'(S_AXI_RRESP), 0);
        d = S_AXI_RDATA;
        @(negedge ACLK);
    endtask

    task automatic wait_irq(output int lat);
        int ok;
        ok = 0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (IRQ) begin ok = 1; lat = cyc - hs_cyc; break; end
        end
        chk("irq_tmo", ok, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_rd(a, d);
        chk(tag, d, exp);
    endtask

    logic [31:0] d, a, b, eq, er, est;
    int          lat, h;

    initial begin
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("rst_ctl", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, IRQ}), 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        ARESET = 1'b0;

        // Basic register access
        axi_wr(5'h00, 32'd1, 4'hF, 1);
        axi_wr(5'h04, 32'd2, 4'hF, 1);
        axi_wr(5'h08, 32'd4, 4'hF, 1);
        rd_chk("rb_dividend", 5'h00, 32'd1);
        rd_chk("rb_divisor", 5'h04, 32'd2);
        rd_chk("rb_ctrl", 5'h08, 32'h4);

        // Byte strobes and unmapped slots
        axi_wr(5'h00, 32'hAABBCCDD, 4'hF, 1);
        axi_wr(5'h00, 32'h11223344, 4'b0101, 1);
        rd_chk("wstrb", 5'h00, 32'hAA22CC44);
        axi_wr(5'h14, 32'hDEADBEEF, 4'hF, 1);
        rd_chk("unmapped", 5'h14, 32'h0);

        // 100 / 7 with latency and BUSY
        axi_wr(5'h00, 32'd100, 4'hF, 1);
        axi_wr(5'h04, 32'd7, 4'hF, 1);
        axi_wr(5'h08, 32'h5, 4'hF, 1);
        rd_chk("busy", 5'h08, 32'hC);
        wait_irq(lat);
        chk("lat34", lat, 34);
        rd_chk("q100_7", 5'h0C, 32'd14);
        rd_chk("r100_7", 5'h10, 32'd2);
        rd_chk("st_done", 5'h08, 32'h6);

        // Operand and START writes while busy leave the running divide alone
        axi_wr(5'h08, 32'h5, 4'hF, 1);
        axi_wr(5'h04, 32'd3, 4'hF, 1);
        axi_wr(5'h08, 32'h5, 4'hF, 1);
        wait_irq(lat);
        rd_chk("mid_q", 5'h0C, 32'd14);
        rd_chk("mid_r", 5'h10, 32'd2);
        rd_chk("mid_dsr", 5'h04, 32'd3);
        axi_wr(5'h08, 32'h2, 4'hF, 1);
        chk("irq_clr", 32'(IRQ), 0);
        rd_chk("st_clr", 5'h08, 32'h0);

        // Max dividend, then divide by zero
        axi_wr(5'h00, 32'hFFFFFFFF, 4'hF, 1);
        axi_wr(5'h04, 32'd1, 4'hF, 1);
        axi_wr(5'h08, 32'h5, 4'hF, 1);
        wait_irq(lat);
        rd_chk("qmax", 5'h0C, 32'hFFFFFFFF);
        rd_chk("rmax", 5'h10, 32'h0);
        axi_wr(5'h04, 32'd0, 4'hF, 1);
        axi_wr(5'h08, 32'h5, 4'hF, 1);
        wait_irq(lat);
        chk("dz_lat", 32'(lat >= 1 && lat <= 2), 1);
        rd_chk("dz_st", 5'h08, 32'h16);
        rd_chk("dz_q", 5'h0C, 32'hFFFFFFFF);
        rd_chk("dz_r", 5'h10, 32'hFFFFFFFF);

        // Write response backpressure with a queued second write
        S_AXI_BREADY = 1'b0;
        axi_wr(5'h00, 32'h1234, 4'hF, 0);
        S_AXI_AWADDR = 5'h04; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            chk("bp_w", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'h4);
        end
        S_AXI_BREADY = 1'b1;
        axi_wr(5'h04, 32'h55, 4'hF, 1);
        rd_chk("bp_w0", 5'h00, 32'h1234);
        rd_chk("bp_w1", 5'h04, 32'h55);

        // Read data backpressure
        S_AXI_RREADY = 1'b0;
        axi_rd(5'h00, d);
        chk("bp_rd", d, 32'h1234);
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            chk("bp_rv", 32'(S_AXI_RVALID), 1);
            chk("bp_rdat", S_AXI_RDATA, 32'h1234);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        chk("bp_rdone", 32'(S_AXI_RVALID), 0);

        // Randomized divides against arithmetic reference
        for (int n = 0; n < 16; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            if (b == 0) begin
                eq = 32'hFFFFFFFF; er = a; est = 32'h16;
            end else begin
                eq = a / b; er = a % b; est = 32'h6;
            end
            axi_wr(5'h00, a, 4'hF, 1);
            axi_wr(5'h04, b, 4'hF, 1);
            axi_wr(5'h08, 32'h5, 4'hF, 1);
            h = hs_cyc;
            wait_irq(lat);
            if (b == 0) chk("rnd_lat", 32'(lat >= 1 && lat <= 2), 1);
            else        chk("rnd_lat", lat, 34);
            rd_chk("rnd_q", 5'h0C, eq);
            rd_chk("rnd_r", 5'h10, er);
            rd_chk("rnd_st", 5'h08, est);
            chk("rnd_hs", 32'(hs_cyc - h), 0);
        end

        // Asynchronous reset mid-divide with a read response pending
        axi_wr(5'h00, 32'd100, 4'hF, 1);
        axi_wr(5'h04, 32'd7, 4'hF, 1);
        axi_wr(5'h08, 32'h5, 4'hF, 1);
        S_AXI_RREADY = 1'b0;
        repeat (6) @(negedge ACLK);
        axi_rd(5'h00, d);
        chk("pre_rst_rd", d, 32'd100);
        #2 ARESET = 1'b1;
        #1;
        chk("arst_ctl", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, IRQ}), 0);
        chk("arst_rdata", S_AXI_RDATA, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        S_AXI_RREADY = 1'b1;
        rd_chk("post_rst_st", 5'h08, 32'h0);
        rd_chk("post_rst_dvd", 5'h00, 32'h0);
        axi_wr(5'h00, 32'd20, 4'hF, 1);
        axi_wr(5'h04, 32'd5, 4'hF, 1);
        axi_wr(5'h08, 32'h5, 4'hF, 1);
        wait_irq(lat);
        chk("post_rst_lat", lat, 34);
        rd_chk("q20_5", 5'h0C, 32'd4);
        rd_chk("r20_5", 5'h10, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
